// File: rtl/stat_display_mux.sv
// rtl/stat_display_mux.sv - event counter bank and display channel selector
module stat_display_mux #(
  parameter int WIDTH      = 32,
  parameter int NEXT       = 3,
  parameter int NCNT       = 4,
  parameter int SELW       = 3,
  parameter int SCROLL_DIV = 50000000,
  parameter int SATURATE   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NEXT*WIDTH-1:0] ext_data,
  input  logic [NCNT-1:0]      evt,
  input  logic                 halt,
  input  logic                 clr,
  input  logic [SELW-1:0]      sel,
  input  logic                 scroll,
  input  logic                 freeze,
  output logic [WIDTH-1:0]     disp_data,
  output logic [SELW-1:0]      disp_idx,
  output logic [NCNT-1:0]      cnt_ovf
);

  localparam int NCH  = NEXT + NCNT;
  localparam int DIVW = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [SELW:0]   NCH_L    = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(NCH - 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCROLL_DIV - 1);

  // Reject configurations whose channel count does not fit the select field.
  if (NCH > (1 << SELW)) begin : g_bad_selw
    $error("stat_display_mux: NEXT+NCNT exceeds 2**SELW");
  end
  if (SCROLL_DIV < 2) begin : g_bad_div
    $error("stat_display_mux: SCROLL_DIV must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCROLL = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] cnt [NCNT];
  logic [SELW-1:0]  scroll_idx;
  logic [DIVW-1:0]  div_cnt;

  logic             load_scroll;
  logic             div_run;
  logic             hold;
  logic [SELW-1:0]  idx;
  logic             in_range;
  logic [WIDTH-1:0] chan_val;

  // Event counters: clear wins, halt blocks counting, top value saturates or wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      cnt_ovf <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (clr) begin
          cnt[i]     <= '0;
          cnt_ovf[i] <= 1'b0;
        end else if (evt[i] && !halt) begin
          if (&cnt[i]) begin
            cnt_ovf[i] <= 1'b1;
            cnt[i]     <= (SATURATE != 0) ? cnt[i] : '0;
          end else begin
            cnt[i] <= cnt[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  // Display mode state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_MANUAL;
    else       state <= state_nxt;
  end

  // Next mode: freeze has priority over scroll from every state.
  always_comb begin
    state_nxt   = state;
    load_scroll = 1'b0;
    if (freeze) begin
      state_nxt = ST_FROZEN;
    end else begin
      case (state)
        ST_MANUAL: begin
          if (scroll) begin
            state_nxt   = ST_SCROLL;
            load_scroll = 1'b1;
          end
        end
        ST_SCROLL: begin
          if (!scroll) state_nxt = ST_MANUAL;
        end
        ST_FROZEN: begin
          state_nxt = scroll ? ST_SCROLL : ST_MANUAL;
        end
        default: state_nxt = ST_MANUAL;
      endcase
    end
  end

  // Output holds on the edge freeze is first seen and for the whole frozen period.
  always_comb begin
    hold    = freeze || (state == ST_FROZEN);
    div_run = (state == ST_SCROLL) && !freeze && scroll;
  end

  // Scroll divider and index; entering scroll starts from the shown channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll_idx <= '0;
      div_cnt    <= '0;
    end else if (load_scroll) begin
      scroll_idx <= disp_idx;
      div_cnt    <= '0;
    end else if (div_run) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt    <= '0;
        scroll_idx <= (scroll_idx == IDX_LAST) ? '0 : scroll_idx + SELW'(1);
      end else begin
        div_cnt <= div_cnt + DIVW'(1);
      end
    end
  end

  // Channel multiplexer: external channels first, then the counters.
  always_comb begin
    idx      = (state == ST_SCROLL) ? scroll_idx : sel;
    in_range = ({1'b0, idx} < NCH_L);
    chan_val = ext_data[0 +: WIDTH];
    for (int k = 0; k < NEXT; k++) begin
      if (idx == SELW'(k)) chan_val = ext_data[k*WIDTH +: WIDTH];
    end
    for (int k = 0; k < NCNT; k++) begin
      if (idx == SELW'(NEXT + k)) chan_val = cnt[k];
    end
  end

  // Registered display; unused indices fall back to channel 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_data <= '0;
      disp_idx  <= '0;
    end else if (!hold) begin
      if (in_range) begin
        disp_data <= chan_val;
        disp_idx  <= idx;
      end else begin
        disp_data <= ext_data[0 +: WIDTH];
        disp_idx  <= '0;
      end
    end
  end

endmodule

// File: doc/stat_display_mux.md
Name: stat_display_mux

Overview:
- Parametrised successor to the CPU statistics/display selector.
- Owns an internal bank of event counters (cycles, jumps, conditional-branch-taken, load-use stalls, etc.) and selects one 32-bit value for the seven-segment driver.
- Selection sources are the external datapath values (syscall output, PC, memory data, …) and the internal counters.
- Adds registered output, auto-scroll mode, display freeze, counter clear and saturation.

Parameters:
- WIDTH, 32: data and counter width.
- NEXT, 3: number of external data channels (channel indices 0..NEXT-1).
- NCNT, 4: number of internal counters (channel indices NEXT..NEXT+NCNT-1).
- SELW, 3: select width; NEXT+NCNT must be ≤ 2^SELW (elaboration error otherwise).
- SCROLL_DIV, 50000000: clk cycles per channel in auto-scroll; must be ≥ 2.
- SATURATE, 1: 1 = counters stick at all-ones; 0 = counters wrap to 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ext_data  in  NEXT*WIDTH  external channels; channel k = bits [k*WIDTH +: WIDTH]
- evt  in  NCNT  per-counter increment strobes, sampled each clk
- halt  in  1  CPU halted; while high, counters do not increment
- clr  in  1  synchronous clear of all counters
- sel  in  SELW  manual channel select
- scroll  in  1  level: 1 = auto-scroll mode
- freeze  in  1  level: 1 = hold the displayed value
- disp_data  out  WIDTH  registered display value
- disp_idx  out  SELW  registered index of the channel currently shown
- cnt_ovf  out  NCNT  sticky per-counter overflow/saturation flag

Behaviour:
- Reset (async, high):
  - all counters = 0, cnt_ovf = 0, scroll divider = 0, scroll index = 0.
  - disp_data = 0, disp_idx = 0.
  - FSM = MANUAL.
- Counters, each clk edge, per counter i:
  - clr = 1: cnt[i] ← 0, cnt_ovf[i] ← 0. clr beats evt and halt.
  - else if evt[i] & !halt:
    - cnt[i] = all-ones: SATURATE = 1 holds the value; SATURATE = 0 wraps to 0. In both cases cnt_ovf[i] ← 1.
    - otherwise cnt[i] ← cnt[i] + 1.
  - else hold.
  - Counters keep counting while the display is frozen.
- FSM states: MANUAL, SCROLL, FROZEN. Evaluation order per edge: freeze, then scroll.
  - freeze = 1 → FROZEN from any state.
  - FROZEN: disp_data and disp_idx hold. On freeze = 0, go to SCROLL if scroll = 1, else MANUAL.
  - MANUAL → SCROLL on scroll = 1. Scroll index loads the current disp_idx; divider clears.
  - SCROLL → MANUAL on scroll = 0.
- Channel index used for display:
  - MANUAL: idx = sel. SCROLL: idx = scroll index.
- Scroll divider:
  - Counts 0..SCROLL_DIV-1 in SCROLL state only.
  - On the terminal count it returns to 0 and scroll index advances by 1.
  - Scroll index wraps from NEXT+NCNT-1 to 0 and never visits unused indices.
  - The divider pauses in FROZEN and resumes from its held value.
- Output register (MANUAL/SCROLL):
  - disp_idx ← idx; disp_data ← channel[idx].
  - If idx ≥ NEXT+NCNT: disp_data ← channel 0 and disp_idx ← 0.
- Latency:
  - sel change → disp_data updated 1 clk later.
  - evt strobe → counter updated at the next edge → shown on disp_data 2 clk after the strobe cycle.
  - freeze assertion takes effect at the first edge where it is sampled high; the value registered at that edge is not updated.
- Reset mid-scroll or mid-freeze returns to MANUAL with all counters zeroed.

Test Plan:
- Reset with ext_data ch1 = 0x00400010, then sel = 1 → disp_data = 0x00400010 and disp_idx = 1 one clk later; before that, disp_data = 0.
- sel = 3 (counter 0), evt[0] pulsed 5 cycles with halt = 0, then 3 more cycles with halt = 1 → disp_data = 5. Then clr together with evt[0] → 0.
- SATURATE = 1 and WIDTH = 4: 20 pulses on evt[1] → counter = 0xF, cnt_ovf[1] = 1. SATURATE = 0: 16 pulses → counter = 0, cnt_ovf[1] = 1.
- SCROLL_DIV = 4, NEXT+NCNT = 7, scroll = 1 from idx 5 → disp_idx sequence 5,6,0,1 with each index shown 4 clk; indices 7 and above never appear.
- In scroll, assert freeze for 10 clk while evt[2] pulses → disp_data and disp_idx constant. After release, scrolling resumes with the divider continuing, and counter 2 reflects all 10 events.
- sel = 7 with NEXT+NCNT = 7 → disp_data = ext ch0 and disp_idx = 0. Async reset asserted mid-cycle → outputs 0 immediately, without waiting for a clk edge.
